// File: rtl/led_flow_ctrl.sv
// LED flow controller: stepped LED patterns with a req/ack mode-change handshake.
// Optional ping-pong mode enabled by defining LED_FLOW_PINGPONG_EN.
module led_flow_ctrl #(
    parameter logic [23:0] CNT_MAX = 24'd2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       mode_req,
    input  logic [1:0] mode_sel,
    input  logic       pause,
    output logic       mode_ack,
    output logic       tick_out,
    output logic [7:0] led_out
);

    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    localparam logic [1:0] M_LEFT  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_PP    = 2'b10;
    localparam logic [1:0] M_BLINK = 2'b11;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [23:0] cnt;
    logic [1:0]  mode;
    logic [1:0]  mode_load;
    logic [7:0]  seed;
    logic [7:0]  step_pat;
    logic        start_load;
    logic        advance;
    logic        wrap;
`ifdef LED_FLOW_PINGPONG_EN
    logic        dir;
    logic        dir_nxt;
`endif

    // A pending request wins over pause and over a coincident step;
    // the LOAD cycle itself ignores mode_req (requester is still holding it).
    always_comb begin
        start_load = (state != LOAD) && mode_req;
        advance    = !pause && !start_load;
        wrap       = advance && (cnt == CNT_MAX);
        if (start_load) begin
            state_nxt = LOAD;
        end else if (pause) begin
            state_nxt = HOLD;
        end else begin
            state_nxt = RUN;
        end
    end

    // Mode actually stored and the pattern it starts from.
    always_comb begin
`ifdef LED_FLOW_PINGPONG_EN
        mode_load = mode_sel;
`else
        mode_load = (mode_sel == M_PP) ? M_LEFT : mode_sel;
`endif
        if (mode_load == M_RIGHT) begin
            seed = 8'h80;
        end else if (mode_load == M_BLINK) begin
            seed = 8'hFF;
        end else begin
            seed = 8'h01;
        end
    end

    // Next pattern for the current mode.
    always_comb begin
        step_pat = {led_out[6:0], led_out[7]};
`ifdef LED_FLOW_PINGPONG_EN
        dir_nxt  = dir;
`endif
        unique case (mode)
            M_RIGHT: step_pat = {led_out[0], led_out[7:1]};
            M_BLINK: step_pat = ~led_out;
`ifdef LED_FLOW_PINGPONG_EN
            M_PP: begin
                if (!dir) begin
                    step_pat = led_out << 1;
                    if (led_out == 8'h40) begin
                        dir_nxt = 1'b1;
                    end
                end else begin
                    step_pat = led_out >> 1;
                    if (led_out == 8'h02) begin
                        dir_nxt = 1'b0;
                    end
                end
            end
`endif
            default: step_pat = {led_out[6:0], led_out[7]};
        endcase
    end

    // State, counter, pattern and strobes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= RUN;
            cnt      <= 24'd0;
            mode     <= M_LEFT;
            led_out  <= 8'h01;
            mode_ack <= 1'b0;
            tick_out <= 1'b0;
`ifdef LED_FLOW_PINGPONG_EN
            dir      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            mode_ack <= start_load;
            tick_out <= wrap;
            if (start_load) begin
                mode    <= mode_load;
                cnt     <= 24'd0;
                led_out <= seed;
`ifdef LED_FLOW_PINGPONG_EN
                dir     <= 1'b0;
`endif
            end else if (advance) begin
                if (wrap) begin
                    cnt     <= 24'd0;
                    led_out <= step_pat;
`ifdef LED_FLOW_PINGPONG_EN
                    dir     <= dir_nxt;
`endif
                end else begin
                    cnt <= cnt + 24'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl: directed stimulus, expected events queued
// and consumed by a monitor whenever tick_out or mode_ack fires.
module tb_led_flow_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       pause;
    logic       mode_ack;
    logic       tick_out;
    logic [7:0] led_out;

    typedef struct {
        logic       ack;
        logic [7:0] led;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;

`ifdef LED_FLOW_PINGPONG_EN
    logic [7:0] pp_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
                                8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    localparam logic [7:0] PP_LAST  = 8'h02;
    localparam logic [7:0] PP_AFTER = 8'h04;
`else
    logic [7:0] pp_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                8'h40, 8'h80, 8'h01, 8'h02, 8'h04,
                                8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    localparam logic [7:0] PP_LAST  = 8'h80;
    localparam logic [7:0] PP_AFTER = 8'h01;
`endif

    led_flow_ctrl #(.CNT_MAX(24'd2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mode_req  (mode_req),
        .mode_sel  (mode_sel),
        .pause     (pause),
        .mode_ack  (mode_ack),
        .tick_out  (tick_out),
        .led_out   (led_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edges seen since reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    // Monitor: every strobe must match the head of the queue.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (tick_out && mode_ack) begin
                checks++;
                errors++;
                $display("FAIL tick_ack_overlap cyc=%0d", cyc);
            end
            if (tick_out || mode_ack) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d ack=%0b tick=%0b led=%h",
                             cyc, mode_ack, tick_out, led_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (e.ack != mode_ack || e.led != led_out || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL event got ack=%0b led=%h cyc=%0d need ack=%0b led=%h cyc=%0d",
                                 mode_ack, led_out, cyc, e.ack, e.led, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h need=%h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        int g;
        g = 0;
        while (cyc < k && g < 500) begin
            @(negedge sys_clk);
            g++;
        end
        checks++;
        if (cyc != k) begin
            errors++;
            $display("FAIL wait_cyc got=%0d need=%0d", cyc, k);
        end
    endtask

    task automatic push_step(input logic [7:0] led, input int at);
        q.push_back('{ack: 1'b0, led: led, cyc: at});
    endtask

    task automatic do_mode(input logic [1:0] sel, input logic p, input logic [7:0] seed);
        int g;
        q.push_back('{ack: 1'b1, led: seed, cyc: cyc + 1});
        mode_sel = sel;
        pause    = p;
        mode_req = 1'b1;
        g = 0;
        do begin
            @(negedge sys_clk);
            g++;
        end while (!mode_ack && g < 8);
        checks++;
        if (!mode_ack) begin
            errors++;
            $display("FAIL ack_timeout got=0 need=1");
        end
        mode_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        sys_rst_n = 1'b0;
        mode_req  = 1'b0;
        mode_sel  = 2'b00;
        pause     = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_led", led_out, 8'h01);
        chk("rst_ack", {7'd0, mode_ack}, 8'h00);
        chk("rst_tick", {7'd0, tick_out}, 8'h00);

        // Flow-left from reset: step every 3rd edge.
        for (int i = 1; i <= 8; i++) begin
            push_step(8'h01 << (i % 8), 3 * i);
        end
        sys_rst_n = 1'b1;
        wait_cyc(25);

        // Switch to flow-right.
        mode_sel = 2'b01;
        do_mode(2'b01, 1'b0, 8'h80);
        push_step(8'h40, 29);
        push_step(8'h20, 32);
        wait_cyc(33);

        // Ping-pong (or flow-left when the option is off).
        do_mode(2'b10, 1'b0, 8'h01);
        for (int i = 0; i < 15; i++) begin
            push_step(pp_seq[i], 37 + 3 * i);
        end
        wait_cyc(80);

        // Pause at counter==1 for five cycles.
        push_step(PP_AFTER, 87);
        pause = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("pause_led", led_out, PP_LAST);
        repeat (2) @(negedge sys_clk);
        pause = 1'b0;
        wait_cyc(88);

        // Blink request together with pause: seed, then hold.
        do_mode(2'b11, 1'b1, 8'hFF);
        wait_cyc(93);
        chk("hold_led", led_out, 8'hFF);
        push_step(8'h00, 96);
        pause = 1'b0;
        wait_cyc(97);

        // Re-request the current mode: re-seed from 00 to FF.
        do_mode(2'b11, 1'b0, 8'hFF);
        push_step(8'h00, 101);
        push_step(8'hFF, 104);
        wait_cyc(105);

        // Reset asserted in the middle of LOAD.
        q.push_back('{ack: 1'b1, led: 8'h80, cyc: 106});
        mode_sel = 2'b01;
        mode_req = 1'b1;
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        mode_req  = 1'b0;
        #1;
        chk("midload_led", led_out, 8'h01);
        chk("midload_ack", {7'd0, mode_ack}, 8'h00);
        chk("midload_tick", {7'd0, tick_out}, 8'h00);
        @(negedge sys_clk);
        @(negedge sys_clk);
        push_step(8'h02, 3);
        push_step(8'h04, 6);
        sys_rst_n = 1'b1;
        wait_cyc(7);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d need=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
